cga_isa_bridge: RTL and testbench
=================================

# cga_isa_bridge

Bridges the Next186 CPU's single-cycle memory/IO request port onto the ISA-style strobe bus consumed by the CGA card core (bus_a, bus_memr_l/bus_memw_l/bus_ior_l/bus_iow_l, bus_d, bus_out, bus_rdy). It sits directly upstream of the CGA top level and runs on the same clock. It sequences address setup, strobe pulse, wait states driven by bus_rdy, and recovery. It returns read data and a one-cycle acknowledge, with a timeout if the card never becomes ready.

## Interface
- SETUP_CYC, 1: cycles of address/ALE setup before the strobe (≥1)
- STROBE_MIN, 2: minimum strobe width in cycles (≥1)
- TIMEOUT, 255: maximum strobe cycles before forced termination (>STROBE_MIN, ≤255)
- clk  in  1  card clock, shared with the CGA core
- reset_l  in  1  asynchronous, active-low reset
- cpu_req  in  1  request pulse; sampled only in IDLE
- cpu_we  in  1  1 = write, 0 = read
- cpu_io  in  1  1 = IO space, 0 = memory space
- cpu_addr  in  20  byte address
- cpu_wdata  in  8  write data
- cpu_busy  out  1  transaction in progress
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  8  read data, valid from cpu_ack onward until next ack
- cpu_timeout  out  1  set with cpu_ack if the cycle timed out; held until next ack
- bus_a  out  20  latched address
- bus_d  out  16  {8'h00, latched write data}
- bus_memr_l, bus_memw_l, bus_ior_l, bus_iow_l  out  1 each  active-low strobes
- bus_ale  out  1  address latch enable
- bus_aen  out  1  constant 0 (CPU cycles only)
- bus_out  in  8  card read data
- bus_rdy  in  1  card ready; low inserts wait states

## Operation
- States: IDLE, SETUP, STROBE, RECOVER.
- IDLE: cpu_busy=0. On cpu_req=1, latch we/io/addr/wdata into bus_a/bus_d and go to SETUP. cpu_req in any other state is ignored and not queued.
- SETUP: lasts SETUP_CYC cycles. bus_ale=1 in the first SETUP cycle only. No strobe is asserted.
- STROBE: exactly one strobe is low, selected by {io,we}: mem rd→memr_l, mem wr→memw_l, io rd→ior_l, io wr→iow_l. An 8-bit strobe counter starts at 0 on entry and increments each cycle.
  - Normal exit: counter ≥ STROBE_MIN−1 and bus_rdy=1. On that edge, bus_out is captured into cpu_rdata (reads only; writes leave it unchanged) and cpu_timeout is cleared.
  - Timeout exit: counter = TIMEOUT−1 with bus_rdy=0. cpu_rdata is set to 8'hFF on reads and cpu_timeout is set.
  - If both exit conditions hold in the same cycle, the normal exit wins.
- RECOVER: one cycle. All strobes are high, bus_a and bus_d are still held, cpu_ack=1. Next state is IDLE.
- bus_a and bus_d hold their last values in IDLE; they do not return to zero.
- cpu_busy=1 in SETUP, STROBE and RECOVER.
- Strobes must never glitch: drive them from registers, decoded from the state and the latched {io,we}.

## Timing
- Reset (asynchronous, on reset_l low): state IDLE, all strobes 1, bus_ale=0, bus_aen=0, bus_a=0, bus_d=0, cpu_ack=0, cpu_busy=0, cpu_rdata=0, cpu_timeout=0, counters 0.
- Reset asserted mid-transaction: strobes release immediately (asynchronously), no ack is issued, and the transaction is dropped.
- Define edge 0 as the edge at which cpu_req is sampled in IDLE.
  - SETUP spans cycles 1..SETUP_CYC.
  - STROBE starts at cycle SETUP_CYC+1.
  - With bus_rdy held high, cpu_ack is high in cycle SETUP_CYC+STROBE_MIN+1. With defaults this is cycle 4.
  - Earliest next accept is cycle SETUP_CYC+STROBE_MIN+2 (default 5).
- Each cycle bus_rdy is low past the minimum adds exactly one strobe cycle.
- bus_rdy and bus_out are sampled directly with no synchronizer, since they share clk.
- Worst-case ack occurs at cycle SETUP_CYC+TIMEOUT+1.

## Test plan
- Memory read at B8000h, bus_rdy=1, bus_out=8'h41, defaults: ALE high in cycle 1; memr_l low in cycles 2–3; ack in cycle 4 with cpu_rdata=8'h41 and cpu_timeout=0.
- IO write of 8'h29 to 3D8h: iow_l low for 2 cycles; bus_d=16'h0029 and bus_a=3D8h held through RECOVER; ack in cycle 4; cpu_rdata unchanged.
- Memory write with bus_rdy low for 5 cycles starting at strobe entry: memw_l low for 6 cycles; ack in cycle 8.
- Read with bus_rdy held low and TIMEOUT=16: ack in cycle 18 with cpu_timeout=1 and cpu_rdata=8'hFF. The following normal read clears cpu_timeout.
- cpu_req pulsed in cycles 2 and 4 of an active transaction: both ignored, only one strobe pulse occurs. A req in cycle 5 is accepted.
- reset_l low during STROBE: strobe high within the same cycle, no ack, all outputs at reset values. After release, a new read completes normally.

Source files
------------

// File: rtl/cga_isa_bridge.sv
// Bridges the Next186 single-cycle request port onto the CGA core's ISA-style
// strobe bus: address setup, registered strobe with bus_rdy wait states, recovery.
module cga_isa_bridge #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_MIN = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_io,
  input  logic [19:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_busy,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_timeout,
  output logic [19:0] bus_a,
  output logic [15:0] bus_d,
  output logic        bus_memr_l,
  output logic        bus_memw_l,
  output logic        bus_ior_l,
  output logic        bus_iow_l,
  output logic        bus_ale,
  output logic        bus_aen,
  input  logic [7:0]  bus_out,
  input  logic        bus_rdy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETUP   = 2'd1;
  localparam logic [1:0] STROBE  = 2'd2;
  localparam logic [1:0] RECOVER = 2'd3;

  localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LAST = 8'(STROBE_MIN - 1);
  localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic [7:0] setup_cnt;
  logic [7:0] strobe_cnt;
  logic       lat_we;
  logic       lat_io;
  logic [3:0] strobe_l;
  logic       normal_exit;
  logic       timeout_exit;

  // Normal termination takes priority when both conditions meet on the last count.
  assign normal_exit  = (strobe_cnt >= STROBE_LAST) && bus_rdy;
  assign timeout_exit = (strobe_cnt == TMO_LAST) && !bus_rdy;

  assign cpu_busy = (state != IDLE);
  assign bus_aen  = 1'b0;
  assign {bus_iow_l, bus_ior_l, bus_memw_l, bus_memr_l} = strobe_l;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state       <= IDLE;
      setup_cnt   <= 8'd0;
      strobe_cnt  <= 8'd0;
      lat_we      <= 1'b0;
      lat_io      <= 1'b0;
      strobe_l    <= 4'hF;
      bus_ale     <= 1'b0;
      bus_a       <= 20'd0;
      bus_d       <= 16'd0;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= 8'd0;
      cpu_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cpu_ack <= 1'b0;
          if (cpu_req) begin
            lat_we    <= cpu_we;
            lat_io    <= cpu_io;
            bus_a     <= cpu_addr;
            bus_d     <= {8'h00, cpu_wdata};
            bus_ale   <= 1'b1;
            setup_cnt <= 8'd0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          bus_ale <= 1'b0;
          if (setup_cnt == SETUP_LAST) begin
            // One-hot low strobe indexed by {io,we}: memr, memw, ior, iow.
            strobe_l   <= ~(4'b0001 << {lat_io, lat_we});
            strobe_cnt <= 8'd0;
            state      <= STROBE;
          end else begin
            setup_cnt <= setup_cnt + 8'd1;
          end
        end
        STROBE: begin
          if (normal_exit || timeout_exit) begin
            strobe_l    <= 4'hF;
            cpu_ack     <= 1'b1;
            cpu_timeout <= !normal_exit;
            if (!lat_we) cpu_rdata <= normal_exit ? bus_out : 8'hFF;
            state       <= RECOVER;
          end else begin
            strobe_cnt <= strobe_cnt + 8'd1;
          end
        end
        default: begin
          cpu_ack <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cga_isa_bridge.sv
// Self-checking bench for cga_isa_bridge: transaction-level timeline model,
// per-cycle compare process, directed cases from the test plan plus random traffic.
module tb_cga_isa_bridge;

  localparam int SETUP_CYC  = 1;
  localparam int STROBE_MIN = 2;
  localparam int TIMEOUT    = 16;

  logic        clk = 1'b0;
  logic        reset_l;
  logic        cpu_req, cpu_we, cpu_io;
  logic [19:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_busy, cpu_ack, cpu_timeout;
  logic [7:0]  cpu_rdata;
  logic [19:0] bus_a;
  logic [15:0] bus_d;
  logic        bus_memr_l, bus_memw_l, bus_ior_l, bus_iow_l;
  logic        bus_ale, bus_aen;
  logic [7:0]  bus_out;
  logic        bus_rdy;

  int vectors = 0;
  int miscompares = 0;

  bit          chk_en = 1'b0;
  logic        exp_busy, exp_ack, exp_ale, exp_tmo;
  logic [3:0]  exp_strb;
  logic [19:0] exp_a;
  logic [15:0] exp_d;
  logic [7:0]  exp_rdata;

  logic [19:0] m_a;
  logic [15:0] m_d;
  logic [7:0]  m_rdata;
  logic        m_tmo;

  always #5 clk = ~clk;

  cga_isa_bridge #(
    .SETUP_CYC (SETUP_CYC),
    .STROBE_MIN(STROBE_MIN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset_l    (reset_l),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_io     (cpu_io),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_busy   (cpu_busy),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .cpu_timeout(cpu_timeout),
    .bus_a      (bus_a),
    .bus_d      (bus_d),
    .bus_memr_l (bus_memr_l),
    .bus_memw_l (bus_memw_l),
    .bus_ior_l  (bus_ior_l),
    .bus_iow_l  (bus_iow_l),
    .bus_ale    (bus_ale),
    .bus_aen    (bus_aen),
    .bus_out    (bus_out),
    .bus_rdy    (bus_rdy)
  );

  task automatic checkOutput(input string name, input logic [19:0] act, input logic [19:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against whatever the model has placed in exp_*.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("busy",    20'(cpu_busy),    20'(exp_busy));
      checkOutput("ack",     20'(cpu_ack),     20'(exp_ack));
      checkOutput("ale",     20'(bus_ale),     20'(exp_ale));
      checkOutput("aen",     20'(bus_aen),     20'd0);
      checkOutput("strobes", 20'({bus_iow_l, bus_ior_l, bus_memw_l, bus_memr_l}), 20'(exp_strb));
      checkOutput("bus_a",   bus_a,            exp_a);
      checkOutput("bus_d",   20'(bus_d),       20'(exp_d));
      checkOutput("rdata",   20'(cpu_rdata),   20'(exp_rdata));
      checkOutput("timeout", 20'(cpu_timeout), 20'(exp_tmo));
    end
  end

  task automatic setIdleExpect();
    exp_busy  = 1'b0;
    exp_ack   = 1'b0;
    exp_ale   = 1'b0;
    exp_strb  = 4'hF;
    exp_a     = m_a;
    exp_d     = m_d;
    exp_rdata = m_rdata;
    exp_tmo   = m_tmo;
  endtask

  task automatic randomizeCpuLines();
    cpu_we    = 1'($urandom);
    cpu_io    = 1'($urandom);
    cpu_addr  = 20'($urandom);
    cpu_wdata = 8'($urandom);
  endtask

  task automatic idleCycle();
    cpu_req = 1'b0;
    randomizeCpuLines();
    bus_rdy = 1'($urandom);
    bus_out = 8'($urandom);
    setIdleExpect();
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  // rdy_mode: 0 = low for low_len strobe cycles then high, 1 = held low,
  // 2 = random. inject: 0 none, 1 = req in cycles 2 and 4, 2 = random.
  // rst_cyc: cycle in which reset_l is pulled low (0 = never).
  task automatic applyStimulus(input bit we, input bit io, input logic [19:0] addr,
                               input logic [7:0] wdata, input logic [7:0] out_val,
                               input int rdy_mode, input int low_len, input int inject,
                               input int rst_cyc, output int ack_cyc, output int strb_cnt);
    bit rdy_seq [256];
    int exit_k, a, k;
    bit timed;
    for (int i = 0; i < 256; i++)
      rdy_seq[i] = (rdy_mode == 0) ? (i >= low_len) :
                   (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    timed  = 1'b1;
    exit_k = TIMEOUT - 1;
    for (int i = STROBE_MIN - 1; i <= TIMEOUT - 1; i++) begin
      if (rdy_seq[i]) begin
        exit_k = i;
        timed  = 1'b0;
        break;
      end
    end
    a = SETUP_CYC + 2 + exit_k;
    ack_cyc  = -1;
    strb_cnt = 0;

    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_io    = io;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    bus_rdy   = 1'($urandom);
    bus_out   = 8'($urandom);
    setIdleExpect();
    @(negedge clk);
    @(posedge clk); #1;
    m_a = addr;
    m_d = {8'h00, wdata};

    for (int c = 1; c <= a; c++) begin
      cpu_req = (inject == 1) ? (c == 2 || c == 4) :
                (inject == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
      randomizeCpuLines();
      k = c - (SETUP_CYC + 1);
      bus_rdy = (k >= 0) ? rdy_seq[k] : 1'($urandom);
      bus_out = (k == exit_k) ? out_val : 8'($urandom);
      if (c == a) begin
        if (!we) m_rdata = timed ? 8'hFF : out_val;
        m_tmo = timed;
      end
      exp_busy  = 1'b1;
      exp_ack   = (c == a);
      exp_ale   = (c == 1);
      exp_strb  = (k >= 0 && k <= exit_k) ? ~(4'b0001 << {io, we}) : 4'hF;
      exp_a     = m_a;
      exp_d     = m_d;
      exp_rdata = m_rdata;
      exp_tmo   = m_tmo;
      if (c == rst_cyc) begin
        #1 reset_l = 1'b0;
        #1;
        checkOutput("rst_strobes", 20'({bus_iow_l, bus_ior_l, bus_memw_l, bus_memr_l}), 20'hF);
        checkOutput("rst_ack",     20'(cpu_ack),  20'd0);
        checkOutput("rst_busy",    20'(cpu_busy), 20'd0);
        checkOutput("rst_bus_a",   bus_a,         20'd0);
        checkOutput("rst_rdata",   20'(cpu_rdata), 20'd0);
        m_a = 20'd0; m_d = 16'd0; m_rdata = 8'd0; m_tmo = 1'b0;
        setIdleExpect();
        @(negedge clk);
        @(posedge clk); #1;
        reset_l = 1'b1;
        return;
      end
      @(negedge clk);
      if (cpu_ack && ack_cyc < 0) ack_cyc = c;
      if ({bus_iow_l, bus_ior_l, bus_memw_l, bus_memr_l} != 4'hF) strb_cnt++;
      @(posedge clk); #1;
    end
    cpu_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ack_c, strb_c;
    reset_l = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_io = 1'b0;
    cpu_addr = 20'd0; cpu_wdata = 8'd0;
    bus_out = 8'd0; bus_rdy = 1'b1;
    m_a = 20'd0; m_d = 16'd0; m_rdata = 8'd0; m_tmo = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy",    20'(cpu_busy), 20'd0);
    checkOutput("reset_strobes", 20'({bus_iow_l, bus_ior_l, bus_memw_l, bus_memr_l}), 20'hF);
    checkOutput("reset_bus_d",   20'(bus_d),    20'd0);
    checkOutput("reset_ale",     20'(bus_ale),  20'd0);
    reset_l = 1'b1;
    setIdleExpect();
    chk_en = 1'b1;
    idleCycle();

    // Memory read at B8000h
    applyStimulus(1'b0, 1'b0, 20'hB8000, 8'h00, 8'h41, 0, 0, 0, 0, ack_c, strb_c);
    checkOutput("mrd_ack_cycle", 20'(ack_c), 20'd4);
    checkOutput("mrd_strobe_len", 20'(strb_c), 20'd2);
    checkOutput("mrd_rdata", 20'(cpu_rdata), 20'h41);
    checkOutput("mrd_timeout", 20'(cpu_timeout), 20'd0);

    // IO write 29h to 3D8h; read data must stay 41h
    applyStimulus(1'b1, 1'b1, 20'h003D8, 8'h29, 8'h77, 0, 0, 0, 0, ack_c, strb_c);
    checkOutput("iow_ack_cycle", 20'(ack_c), 20'd4);
    checkOutput("iow_strobe_len", 20'(strb_c), 20'd2);
    checkOutput("iow_bus_d", 20'(bus_d), 20'h00029);
    checkOutput("iow_bus_a", bus_a, 20'h003D8);
    checkOutput("iow_rdata", 20'(cpu_rdata), 20'h41);

    // Memory write with five wait states
    idleCycle();
    applyStimulus(1'b1, 1'b0, 20'h12345, 8'hA5, 8'h00, 0, 5, 0, 0, ack_c, strb_c);
    checkOutput("mwr_ack_cycle", 20'(ack_c), 20'd8);
    checkOutput("mwr_strobe_len", 20'(strb_c), 20'd6);

    // Timeout read, then a normal read clears the flag
    applyStimulus(1'b0, 1'b1, 20'h003DA, 8'h00, 8'h33, 1, 0, 0, 0, ack_c, strb_c);
    checkOutput("tmo_ack_cycle", 20'(ack_c), 20'd18);
    checkOutput("tmo_flag", 20'(cpu_timeout), 20'd1);
    checkOutput("tmo_rdata", 20'(cpu_rdata), 20'hFF);
    applyStimulus(1'b0, 1'b0, 20'hB8002, 8'h00, 8'h5A, 0, 0, 0, 0, ack_c, strb_c);
    checkOutput("post_tmo_flag", 20'(cpu_timeout), 20'd0);
    checkOutput("post_tmo_rdata", 20'(cpu_rdata), 20'h5A);

    // Requests during a transaction are dropped; back-to-back accept in cycle 5
    applyStimulus(1'b0, 1'b0, 20'hB8004, 8'h00, 8'h11, 0, 0, 1, 0, ack_c, strb_c);
    checkOutput("inj_strobe_len", 20'(strb_c), 20'd2);
    checkOutput("inj_ack_cycle", 20'(ack_c), 20'd4);
    applyStimulus(1'b0, 1'b0, 20'hB8006, 8'h00, 8'h22, 0, 0, 0, 0, ack_c, strb_c);
    checkOutput("b2b_ack_cycle", 20'(ack_c), 20'd4);
    checkOutput("b2b_bus_a", bus_a, 20'hB8006);
    checkOutput("b2b_rdata", 20'(cpu_rdata), 20'h22);

    // Reset in the first strobe cycle, then a normal read
    applyStimulus(1'b0, 1'b0, 20'hB8008, 8'h00, 8'h99, 0, 3, 0, 2, ack_c, strb_c);
    idleCycle();
    applyStimulus(1'b0, 1'b1, 20'h003D9, 8'h00, 8'h6C, 0, 0, 0, 0, ack_c, strb_c);
    checkOutput("after_rst_ack", 20'(ack_c), 20'd4);
    checkOutput("after_rst_rdata", 20'(cpu_rdata), 20'h6C);

    // Random traffic
    for (int t = 0; t < 200; t++) begin
      int gaps;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) idleCycle();
      applyStimulus(1'($urandom), 1'($urandom), 20'($urandom), 8'($urandom), 8'($urandom),
                    $urandom_range(0, 2), $urandom_range(0, 20), 2, 0, ack_c, strb_c);
    end
    idleCycle();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
